weight_rmw_sequencer: RTL and testbench
=======================================

// Module: weight_rmw_sequencer
// PURPOSE
// - Read side of the CD weight-update loop. Walks every hidden-neuron row of one core's weight memory.
// - Per row: reads the packed weight word and presents it, with per-row h states, to Update_Unit_CD.
// - Captures the unit's registered write_back_weight and writes it to the same address.
// - Sits between the core weight BRAM (1-cycle read latency) and Update_Unit_CD.
// PARAMETERS
// - NUM_ROWS  default `NUM_HN_ONECORE  hidden rows (weight words) per core; >=1
// - ROW_W     default $clog2(NUM_ROWS)+(NUM_ROWS==1)  row address width
// - WORD_W    default `BW_WEIGHTS*`NUM_TM_V  packed weight word width
// - VN_W      default `NUM_VN_ONECORE  visible states per core
// PORTS
// - clk             in   1          system clock
// - rst             in   1          asynchronous reset, active-high
// - start           in   1          start a full sweep; sampled only in IDLE
// - v_states_0_in   in   VN_W       positive-phase visible states; latched on accepted start
// - v_states_2_in   in   VN_W       negative-phase visible states; latched on accepted start
// - h_states_0_in   in   NUM_ROWS   positive-phase hidden states; bit r for row r; latched on start
// - h_states_2_in   in   NUM_ROWS   negative-phase hidden states; latched on start
// - busy            out  1          high from accepted start until the DONE state is left
// - done            out  1          one-cycle pulse after the last row write
// - mem_addr        out  ROW_W      BRAM address; shared by read and write
// - mem_re          out  1          BRAM read enable; rdata valid the cycle after
// - mem_rdata       in   WORD_W     BRAM read data
// - mem_we          out  1          BRAM write enable
// - mem_wdata       out  WORD_W     BRAM write data
// - upd_en          out  1          drives Update_Unit_CD en
// - upd_weight      out  WORD_W     drives input_weight
// - upd_v0/upd_v2   out  VN_W       drive v_states_0/v_states_2; latched copies
// - upd_h0/upd_h2   out  1          drive h_states_0/h_states_2; bit [row] of the latched vectors
// - upd_wb_weight   in   WORD_W     write_back_weight from Update_Unit_CD
// BEHAVIOUR
// - Reset: state IDLE, row=0, all outputs 0, latched state vectors 0. Async assert; deassert is synchronized.
// - FSM: IDLE -> RD -> WT -> UPD -> WR -> (RD if row<NUM_ROWS-1, else DONE) -> IDLE.
// - IDLE: start=1 latches all state inputs, sets row=0, sets busy=1, moves to RD.
// - RD:  mem_re=1, mem_addr=row.
// - WT:  mem_rdata is captured into upd_weight at the end of the cycle.
// - UPD: upd_en=1; upd_h0/upd_h2 are valid; the unit registers its result at this cycle's edge.
// - WR:  mem_we=1, mem_addr=row, mem_wdata=upd_wb_weight. Row increments at the end of the cycle.
// - DONE: done=1 for exactly one cycle, busy=1 in this cycle, then IDLE with busy=0.
// - Latency: 4 cycles per row. Sweep = 4*NUM_ROWS+1 cycles from the cycle after start to the done pulse.
// - mem_re and mem_we are never high in the same cycle.
// - mem_addr holds its value outside RD/WR.
// - start while busy is ignored; latched states are not disturbed.
// - start coinciding with the DONE cycle is ignored. A new start is accepted from IDLE only.
// - The row counter never exceeds NUM_ROWS-1 and resets to 0 at every accepted start.
// - NUM_ROWS=1: RD,WT,UPD,WR,DONE.
// - Reset mid-sweep: immediate return to IDLE, mem_we/mem_re/upd_en low, no partial write issued.
//   Rows already written stay updated.
// - Arithmetic: none local. Words pass through unmodified; the update unit owns the delta math.
// CONFIGURATION
// - WB_SKIP_UNCHANGED_EN defined:
//   - In WR, mem_we is asserted only when upd_wb_weight != upd_weight.
//   - Extra output skip_cnt [ROW_W:0] counts suppressed writes. It clears on accepted start and is held after done.
// - WB_SKIP_UNCHANGED_EN undefined: mem_we=1 in every WR cycle and no skip_cnt port exists.
// - Timing is identical in both builds.
// TESTING
// - Reset, then idle 10 cycles -> busy=0, done=0, mem_we=0, mem_re=0 throughout.
// - NUM_ROWS=4, rows preloaded 0x10 each lane, h0=4'b0101, h2=0, v0=all ones, LEARNING_RATE=4.
//   -> done at cycle 17 after start. Rows 0/2 lanes=0x20; rows 1/3 unchanged; 4 writes total.
// - start held high through the whole sweep -> exactly one sweep and one done pulse.
//   Latched states unchanged by mid-sweep toggling of the inputs.
// - rst asserted in UPD of row 2 -> next edge IDLE. Rows 0-1 updated, rows 2-3 untouched. No mem_we during reset.
// - Back-to-back: start asserted the cycle after done -> second sweep accepted, row restarts at 0.
// - WB_SKIP_UNCHANGED_EN with h0=h2=all ones, v0=v2 -> zero mem_we pulses, skip_cnt=NUM_ROWS, done still at 4*NUM_ROWS+1.

Source files
------------

// File: rtl/weight_rmw_sequencer.sv
// Read side of the CD weight-update loop: walks every hidden row, feeds Update_Unit_CD, writes the result back.
// Optional build macro WB_SKIP_UNCHANGED_EN suppresses write-backs whose word did not change.
`ifndef NUM_HN_ONECORE
`define NUM_HN_ONECORE 4
`endif
`ifndef BW_WEIGHTS
`define BW_WEIGHTS 8
`endif
`ifndef NUM_TM_V
`define NUM_TM_V 4
`endif
`ifndef NUM_VN_ONECORE
`define NUM_VN_ONECORE 4
`endif

module weight_rmw_sequencer #(
    parameter int NUM_ROWS = `NUM_HN_ONECORE,
    parameter int ROW_W    = $clog2(NUM_ROWS) + (NUM_ROWS == 1),
    parameter int WORD_W   = `BW_WEIGHTS * `NUM_TM_V,
    parameter int VN_W     = `NUM_VN_ONECORE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [VN_W-1:0]     v_states_0_in,
    input  logic [VN_W-1:0]     v_states_2_in,
    input  logic [NUM_ROWS-1:0] h_states_0_in,
    input  logic [NUM_ROWS-1:0] h_states_2_in,
    output logic                busy,
    output logic                done,
    output logic [ROW_W-1:0]    mem_addr,
    output logic                mem_re,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                mem_we,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                upd_en,
    output logic [WORD_W-1:0]   upd_weight,
    output logic [VN_W-1:0]     upd_v0,
    output logic [VN_W-1:0]     upd_v2,
    output logic                upd_h0,
    output logic                upd_h2,
    input  logic [WORD_W-1:0]   upd_wb_weight
`ifdef WB_SKIP_UNCHANGED_EN
    ,
    output logic [ROW_W:0]      skip_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_UPD, S_WR, S_DONE} state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [WORD_W-1:0]   weight_q, weight_d;
    logic [VN_W-1:0]     v0_q, v0_d, v2_q, v2_d;
    logic [NUM_ROWS-1:0] h0_q, h0_d, h2_q, h2_d;
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_i;
    logic                wr_skip;
    logic                start_acc;

    // Reset asserts asynchronously but releases two edges later, in step with clk.
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= rst_sync_d;
    end
    assign rst_i = rst_sync_q[1];

    assign start_acc = (state_q == S_IDLE) && start;

`ifdef WB_SKIP_UNCHANGED_EN
    logic [ROW_W:0] skip_cnt_q, skip_cnt_d;

    assign wr_skip = (upd_wb_weight == weight_q);

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (start_acc)
            skip_cnt_d = '0;
        else if (state_q == S_WR && wr_skip)
            skip_cnt_d = skip_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) skip_cnt_q <= '0;
        else       skip_cnt_q <= skip_cnt_d;
    end

    assign skip_cnt = skip_cnt_q;
`else
    assign wr_skip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        weight_d = weight_q;
        v0_d     = v0_q;
        v2_d     = v2_q;
        h0_d     = h0_q;
        h2_d     = h2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    v0_d    = v_states_0_in;
                    v2_d    = v_states_2_in;
                    h0_d    = h_states_0_in;
                    h2_d    = h_states_2_in;
                    row_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD:  state_d = S_WT;
            S_WT: begin
                weight_d = mem_rdata;
                state_d  = S_UPD;
            end
            S_UPD: state_d = S_WR;
            // Last row stays put so the counter never runs past the end.
            S_WR: begin
                if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            weight_q <= '0;
            v0_q     <= '0;
            v2_q     <= '0;
            h0_q     <= '0;
            h2_q     <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            weight_q <= weight_d;
            v0_q     <= v0_d;
            v2_q     <= v2_d;
            h0_q     <= h0_d;
            h2_q     <= h2_d;
        end
    end

    // Address tracks the row counter, which only moves on entry to RD.
    assign mem_addr   = row_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mem_re     = (state_q == S_RD);
    assign mem_we     = (state_q == S_WR) && !wr_skip;
    assign mem_wdata  = (state_q == S_WR) ? upd_wb_weight : '0;
    assign upd_en     = (state_q == S_UPD);
    assign upd_weight = weight_q;
    assign upd_v0     = v0_q;
    assign upd_v2     = v2_q;
    assign upd_h0     = h0_q[row_q];
    assign upd_h2     = h2_q[row_q];

endmodule

// File: tb/tb_weight_rmw_sequencer.sv
// Directed bench for weight_rmw_sequencer with a BRAM model and a simple registered update-unit model.
module tb_weight_rmw_sequencer;
    localparam int NR = 4;
    localparam int VN = 4;
    localparam int WW = 32;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [VN-1:0] v0_in = '0, v2_in = '0;
    logic [NR-1:0] h0_in = '0, h2_in = '0;
    logic busy, done, mem_re, mem_we, upd_en, upd_h0, upd_h2;
    logic [RW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata, upd_weight;
    logic [VN-1:0] upd_v0, upd_v2;
    logic [WW-1:0] rdata = '0;
    logic [WW-1:0] wb = '0;
`ifdef WB_SKIP_UNCHANGED_EN
    logic [RW:0] skip_cnt;
`endif

    logic [WW-1:0] mem [NR];
    logic [WW-1:0] pre_data [NR];
    logic pre_en = 1'b0;

    int checks = 0, failures = 0;
    int wr_cnt = 0, done_cnt = 0, both_hi = 0;

    weight_rmw_sequencer #(.NUM_ROWS(NR), .WORD_W(WW), .VN_W(VN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .v_states_0_in(v0_in), .v_states_2_in(v2_in),
        .h_states_0_in(h0_in), .h_states_2_in(h2_in),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .upd_en(upd_en), .upd_weight(upd_weight), .upd_v0(upd_v0), .upd_v2(upd_v2),
        .upd_h0(upd_h0), .upd_h2(upd_h2), .upd_wb_weight(wb)
`ifdef WB_SKIP_UNCHANGED_EN
        , .skip_cnt(skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Update-unit model: each lane +0x10 when h0&v0, -0x10 when h2&v2.
    function automatic logic [WW-1:0] unit_f(input logic [WW-1:0] w, input logic [VN-1:0] a0, a2,
                                             input logic b0, b2);
        logic [WW-1:0] r;
        r = w;
        for (int l = 0; l < VN; l++)
            r[l*8 +: 8] = w[l*8 +: 8] + ((b0 && a0[l]) ? 8'h10 : 8'h00) - ((b2 && a2[l]) ? 8'h10 : 8'h00);
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < NR; i++) mem[i] <= pre_data[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) rdata <= mem[mem_addr];
        if (upd_en) wb <= unit_f(upd_weight, upd_v0, upd_v2, upd_h0, upd_h2);
    end

    always @(negedge clk) begin
        if (mem_we) wr_cnt++;
        if (done) done_cnt++;
        if (mem_we && mem_re) both_hi++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < NR; i++) pre_data[i] = 32'h10101010 + i;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where done is seen (cyc counted from the cycle after start).
    task automatic run_sweep(input logic [NR-1:0] h0, h2, input logic [VN-1:0] v0, v2,
                             input bit hold, input bit toggle, output int cyc);
        h0_in = h0; h2_in = h2; v0_in = v0; v2_in = v2;
        start = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) chk("rd_row0", {mem_re, busy, 6'(mem_addr)}, {1'b1, 1'b1, 6'd0});
            if (toggle && c == 5) begin
                h0_in = ~h0_in; h2_in = ~h2_in; v0_in = ~v0_in; v2_in = ~v2_in;
            end
            if (done) begin
                cyc = c;
                start = 1'b0;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic [NR-1:0] h0, h2;
        logic [VN-1:0] v0, v2;
        logic [NR-1:0][WW-1:0] exp;
        int exp_wr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc, w0, d0;

        vecs[0].h0 = 4'b0101; vecs[0].h2 = 4'b0000; vecs[0].v0 = 4'b1111; vecs[0].v2 = 4'b0000;
        vecs[0].exp = {32'h10101013, 32'h20202022, 32'h10101011, 32'h20202020};
        vecs[1].h0 = 4'b0000; vecs[1].h2 = 4'b1010; vecs[1].v0 = 4'b0000; vecs[1].v2 = 4'b0011;
        vecs[1].exp = {32'h10100003, 32'h10101012, 32'h10100001, 32'h10101010};
        vecs[2].h0 = 4'b1111; vecs[2].h2 = 4'b1111; vecs[2].v0 = 4'b1001; vecs[2].v2 = 4'b1001;
        vecs[2].exp = {32'h10101013, 32'h10101012, 32'h10101011, 32'h10101010};
        vecs[3].h0 = 4'b1100; vecs[3].h2 = 4'b0100; vecs[3].v0 = 4'b0110; vecs[3].v2 = 4'b0010;
        vecs[3].exp = {32'h10202013, 32'h10201012, 32'h10101011, 32'h10101010};
`ifdef WB_SKIP_UNCHANGED_EN
        vecs[0].exp_wr = 2; vecs[1].exp_wr = 2; vecs[2].exp_wr = 0; vecs[3].exp_wr = 2;
`else
        vecs[0].exp_wr = 4; vecs[1].exp_wr = 4; vecs[2].exp_wr = 4; vecs[3].exp_wr = 4;
`endif

        // Reset state and quiet idle
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, mem_we, mem_re, upd_en, upd_h0, 2'(mem_addr)}, 8'h00);
        chk("reset_words", {upd_weight, mem_wdata}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {busy, done, mem_we, mem_re}, 4'b0000);
        end

        // Table-driven full sweeps
        for (int v = 0; v < 4; v++) begin
            preload();
            w0 = wr_cnt; d0 = done_cnt;
            run_sweep(vecs[v].h0, vecs[v].h2, vecs[v].v0, vecs[v].v2, 1'b0, 1'b0, cyc);
            @(negedge clk);
            chk("done_cycle", cyc, 17);
            for (int i = 0; i < NR; i++) chk("row_word", mem[i], vecs[v].exp[i]);
            chk("write_count", wr_cnt - w0, vecs[v].exp_wr);
            chk("done_pulses", done_cnt - d0, 1);
            chk("idle_after", busy, 1'b0);
`ifdef WB_SKIP_UNCHANGED_EN
            chk("skip_cnt", skip_cnt, 4 - vecs[v].exp_wr);
`endif
        end

        // start held high through the sweep with inputs toggling mid-sweep
        preload();
        w0 = wr_cnt; d0 = done_cnt;
        run_sweep(vecs[0].h0, vecs[0].h2, vecs[0].v0, vecs[0].v2, 1'b1, 1'b1, cyc);
        repeat (3) @(negedge clk);
        chk("hold_done_cycle", cyc, 17);
        chk("hold_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < NR; i++) chk("hold_row_word", mem[i], vecs[0].exp[i]);
        chk("hold_write_count", wr_cnt - w0, vecs[0].exp_wr);

        // start in DONE ignored, then accepted the cycle after (back-to-back)
        preload();
        run_sweep(vecs[2].h0, vecs[2].h2, vecs[2].v0, vecs[2].v2, 1'b0, 1'b0, cyc);
        chk("b2b_first_done", cyc, 17);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", busy, 1'b0);
        d0 = done_cnt;
        run_sweep(vecs[3].h0, vecs[3].h2, vecs[3].v0, vecs[3].v2, 1'b0, 1'b0, cyc);
        @(negedge clk);
        chk("b2b_second_done", cyc, 17);
        chk("b2b_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < NR; i++) chk("b2b_row_word", mem[i], vecs[3].exp[i]);

        // Reset during UPD of row 2
        preload();
        w0 = wr_cnt;
        h0_in = 4'b1111; h2_in = 4'b0000; v0_in = 4'b1111; v2_in = 4'b0000;
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_upd_row2", {upd_en, 2'(mem_addr)}, {1'b1, 2'd2});
        #1 rst = 1'b1;
        #1 chk("rst_immediate", {busy, mem_we, mem_re, upd_en}, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_idle", busy, 1'b0);
        chk("rst_writes", wr_cnt - w0, 2);
        chk("rst_row0", mem[0], 32'h20202020);
        chk("rst_row1", mem[1], 32'h20202021);
        chk("rst_row2", mem[2], 32'h10101012);
        chk("rst_row3", mem[3], 32'h10101013);

        chk("re_we_overlap", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
